// File: rtl/ps2_device_pkg.sv
// Shared PS/2 frame constants and helpers for the device-side transceiver.
package ps2_device_pkg;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic ACK_BIT    = 1'b0;
  localparam logic ODD_PARITY = 1'b1;

  // TX frame slots: 0 start, 1..8 data, 9 parity, 10 stop, 11 released guard half
  localparam logic [3:0] TX_PAR_IDX   = 4'd9;
  localparam logic [3:0] TX_STOP_IDX  = 4'd10;
  localparam logic [3:0] TX_GUARD_IDX = 4'd11;
  // RX clock pulses: 0..7 data, 8 parity, 9 stop, 10 acknowledge
  localparam logic [3:0] RX_PAR_IDX   = 4'd8;
  localparam logic [3:0] RX_STOP_IDX  = 4'd9;
  localparam logic [3:0] RX_ACK_IDX   = 4'd10;

  function automatic logic [10:0] tx_frame(input logic [7:0] b);
    return {STOP_BIT, ODD_PARITY ^ (^b), b, START_BIT};
  endfunction

  function automatic logic parity_ok(input logic [7:0] b, input logic p);
    return ((^{b, p}) == ODD_PARITY);
  endfunction
endpackage

// File: rtl/ps2_device_if.sv
// Byte-level handshake between the PS/2 device transceiver and its user logic.
interface ps2_device_if;
  logic       scan_code_ready;
  logic       scan_code_valid;
  logic [7:0] scan_code_byte;
  logic       command_ready;
  logic       command_valid;
  logic [7:0] command_byte;
  logic       command_error;
  logic       tx_abort;

  modport master (
    input  scan_code_ready, command_valid, command_byte, command_error, tx_abort,
    output scan_code_valid, scan_code_byte, command_ready
  );
  modport slave (
    output scan_code_ready, command_valid, command_byte, command_error, tx_abort,
    input  scan_code_valid, scan_code_byte, command_ready
  );
endinterface

// File: rtl/ps2_bit_timer.sv
// Half-period down-counter with a phase toggle; one half lasts CLK_HALF cycles.
module ps2_bit_timer #(
  parameter int CLK_HALF = 2072
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic start_high,
  input  logic stop,
  output logic half_done,
  output logic phase_high
);
  localparam int CW = $clog2(CLK_HALF);

  logic [CW-1:0] cnt;
  logic          running;

  assign half_done = running && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      running    <= 1'b0;
      phase_high <= 1'b0;
    end else if (stop) begin
      running <= 1'b0;
    end else if (start) begin
      cnt        <= CW'(CLK_HALF - 1);
      running    <= 1'b1;
      phase_high <= start_high;
    end else if (half_done) begin
      cnt        <= CW'(CLK_HALF - 1);
      phase_high <= ~phase_high;
    end else if (running) begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/ps2_device.sv
// PS/2 keyboard-end transceiver: clocks scan codes out, clocks host commands in and acknowledges.
module ps2_device
  import ps2_device_pkg::*;
#(
  parameter int CLK_HALF  = 2072,
  parameter int IDLE_HOLD = 2590
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2_clk_in,
  output logic         ps2_clk_out,
  output logic         ps2_clk_oe,
  input  logic         ps2_data_in,
  output logic         ps2_data_out,
  output logic         ps2_data_oe,
  ps2_device_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, INHIBIT, TX, RX} state_e;
  localparam int IW = $clog2(IDLE_HOLD + 1);

  state_e        state, state_nx;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic [IW-1:0] idle_cnt;
  logic          idle_ok;
  logic          pending;
  logic [7:0]    tx_byte;
  logic [15:0]   frame;
  logic [3:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          rx_par, rx_stop, rx_sample;
  logic          cmd_valid, cmd_err, abort_q;
  logic [7:0]    cmd_byte;
  logic          t_start, t_high, t_stop, half_done, phase_high;
  logic          abort, tx_done, rx_done, scan_ready;

  assign clk_s      = clk_sync[1];
  assign data_s     = data_sync[1];
  assign idle_ok    = (idle_cnt == IW'(IDLE_HOLD));
  assign frame      = {5'b0, tx_frame(tx_byte)};
  assign scan_ready = !pending && !reset;

  ps2_bit_timer #(.CLK_HALF(CLK_HALF)) u_timer (
    .clk(clk), .reset(reset), .start(t_start), .start_high(t_high), .stop(t_stop),
    .half_done(half_done), .phase_high(phase_high)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    t_start  = 1'b0;
    t_high   = 1'b0;
    t_stop   = 1'b0;
    abort    = 1'b0;
    tx_done  = 1'b0;
    rx_done  = 1'b0;
    case (state)
      IDLE:
        if (!clk_s) state_nx = INHIBIT;
        else if (pending && idle_ok) begin
          state_nx = TX;
          t_start  = 1'b1;
          t_high   = 1'b1;
        end
      // request-to-send waits here while an earlier command is still unread
      INHIBIT:
        if (clk_s) begin
          if (data_s) state_nx = IDLE;
          else if (!cmd_valid) begin
            state_nx = RX;
            t_start  = 1'b1;
          end
        end
      TX:
        if (half_done && phase_high) begin
          if (bit_idx <= TX_PAR_IDX && !clk_s) begin
            abort    = 1'b1;
            t_stop   = 1'b1;
            state_nx = INHIBIT;
          end else if (bit_idx == TX_GUARD_IDX) begin
            tx_done  = 1'b1;
            t_stop   = 1'b1;
            state_nx = IDLE;
          end
        end
      RX:
        if (half_done && phase_high && bit_idx == RX_ACK_IDX) begin
          rx_done  = 1'b1;
          t_stop   = 1'b1;
          state_nx = IDLE;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      idle_cnt  <= '0;
      pending   <= 1'b0;
      tx_byte   <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      rx_par    <= 1'b0;
      rx_stop   <= 1'b0;
      rx_sample <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
      cmd_err   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      abort_q   <= abort;
      rx_sample <= (state == RX) && half_done && !phase_high;

      if (state == IDLE && clk_s && data_s) begin
        if (!idle_ok) idle_cnt <= idle_cnt + IW'(1);
      end else idle_cnt <= '0;

      // an aborted frame keeps its byte and restarts from the start bit
      if (scan_ready && bus.scan_code_valid) begin
        pending <= 1'b1;
        tx_byte <= bus.scan_code_byte;
      end else if (tx_done) pending <= 1'b0;

      if (t_start) bit_idx <= '0;
      else if (state == TX && half_done && !phase_high) bit_idx <= bit_idx + 4'd1;
      else if (state == RX && half_done &&  phase_high) bit_idx <= bit_idx + 4'd1;

      if (rx_sample) begin
        if (bit_idx <= 4'd7)              rx_shift <= {data_s, rx_shift[7:1]};
        else if (bit_idx == RX_PAR_IDX)   rx_par   <= data_s;
        else if (bit_idx == RX_STOP_IDX)  rx_stop  <= data_s;
      end

      if (rx_done) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= rx_shift;
        cmd_err   <= (rx_stop != STOP_BIT) || !parity_ok(rx_shift, rx_par);
      end else if (cmd_valid && bus.command_ready) begin
        cmd_valid <= 1'b0;
        cmd_byte  <= '0;
        cmd_err   <= 1'b0;
      end
    end
  end

  assign ps2_clk_out  = 1'b0;
  assign ps2_data_out = 1'b0;
  assign ps2_clk_oe   = ((state == TX) && !phase_high && bit_idx <= TX_STOP_IDX) ||
                        ((state == RX) && !phase_high);
  assign ps2_data_oe  = ((state == TX) && bit_idx <= TX_STOP_IDX && !frame[bit_idx]) ||
                        ((state == RX) && bit_idx == RX_ACK_IDX && rx_stop == STOP_BIT &&
                         ACK_BIT == 1'b0);

  assign bus.scan_code_ready = scan_ready;
  assign bus.command_valid   = cmd_valid;
  assign bus.command_byte    = cmd_byte;
  assign bus.command_error   = cmd_err;
  assign bus.tx_abort        = abort_q;
endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: a behavioural PS/2 host drives the lines and checks frames and handshakes.
module tb_ps2_device;
  localparam int CLK_HALF  = 8;
  localparam int IDLE_HOLD = 10;

  typedef struct {
    logic        is_rx;
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic [10:0] exp_frame;
    logic [7:0]  exp_byte;
    logic        exp_err;
    logic        exp_ack;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic host_clk_low = 1'b0, host_data_low = 1'b0;
  logic ps2_clk_out, ps2_clk_oe, ps2_data_out, ps2_data_oe;
  logic clk_line, data_line;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign clk_line  = !(ps2_clk_oe  || host_clk_low);
  assign data_line = !(ps2_data_oe || host_data_low);

  ps2_device_if bus();

  ps2_device #(.CLK_HALF(CLK_HALF), .IDLE_HOLD(IDLE_HOLD)) dut (
    .clk(clk), .reset(reset),
    .ps2_clk_in(clk_line), .ps2_clk_out(ps2_clk_out), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_in(data_line), .ps2_data_out(ps2_data_out), .ps2_data_oe(ps2_data_oe),
    .bus(bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int ones(input logic [7:0] b);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(b[i]);
    return c;
  endfunction

  function automatic logic model_par(input logic [7:0] b);
    return (ones(b) % 2 == 0);
  endfunction

  // Expected line level at each falling edge, start bit first
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = model_par(b);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_oe(input logic lvl, output bit ok);
    int t = 0;
    while (ps2_clk_oe !== lvl && t < 200) begin @(negedge clk); t++; end
    ok = (ps2_clk_oe === lvl);
  endtask

  task automatic offer(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.scan_code_ready && n < 500) begin @(negedge clk); n++; end
    check("offer_ready", bus.scan_code_ready, 1);
    bus.scan_code_valid = 1'b1;
    bus.scan_code_byte  = b;
    @(negedge clk);
    bus.scan_code_valid = 1'b0;
  endtask

  task automatic tx_capture(input string name, input logic [10:0] exp_frame);
    logic [10:0] got = '0;
    int n = 0, lowc = 0, badw = 0, guard = 0, t = 0;
    logic prev;
    prev = ps2_clk_oe;
    while ((n < 11 || ps2_clk_oe) && t < 3000) begin
      @(negedge clk); t++;
      if (ps2_clk_oe && !prev) begin
        if (n < 11) got[n] = data_line;
        n++;
        lowc = 0;
      end
      if (ps2_clk_oe) lowc++;
      if (!ps2_clk_oe && prev && lowc != CLK_HALF) badw++;
      prev = ps2_clk_oe;
    end
    check($sformatf("%s_pulses", name), n, 11);
    check($sformatf("%s_frame", name), got, exp_frame);
    check($sformatf("%s_lowwidth", name), badw, 0);
    while (!bus.scan_code_ready && guard < 100) begin guard++; @(negedge clk); end
    check($sformatf("%s_guard", name), guard, CLK_HALF);
  endtask

  task automatic rx_host(input logic [7:0] b, input logic par, input logic stop,
                         output bit ok, output bit ack);
    bit w0, w1;
    ok = 1'b1;
    ack = 1'b0;
    @(negedge clk); host_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    host_data_low = 1'b1;
    repeat (10) @(negedge clk);
    host_clk_low = 1'b0;
    for (int k = 0; k < 11; k++) begin
      wait_oe(1'b0, w0);
      wait_oe(1'b1, w1);
      if (!w0 || !w1) ok = 1'b0;
      if (k < 8)       host_data_low = !b[k];
      else if (k == 8) host_data_low = !par;
      else if (k == 9) host_data_low = !stop;
      else begin
        host_data_low = 1'b0;
        repeat (2) @(negedge clk);
        ack = ps2_data_oe;
        wait_oe(1'b0, w0);
        repeat (CLK_HALF - 2) @(negedge clk);
        ack = ack & ps2_data_oe;
      end
    end
  endtask

  task automatic rx_run(input string name, input logic [7:0] b, input logic par, input logic stop,
                        input logic [7:0] eb, input logic ee, input logic ea);
    bit ok, ack;
    int t = 0, d;
    rx_host(b, par, stop, ok, ack);
    check($sformatf("%s_pulses", name), ok, 1);
    check($sformatf("%s_ack", name), ack, ea);
    while (!bus.command_valid && t < 4 * CLK_HALF) begin @(negedge clk); t++; end
    check($sformatf("%s_valid", name), bus.command_valid, 1);
    check($sformatf("%s_byte", name), bus.command_byte, eb);
    check($sformatf("%s_err", name), bus.command_error, ee);
    d = $urandom_range(0, 5);
    repeat (d) @(negedge clk);
    check($sformatf("%s_hold", name), {bus.command_valid, bus.command_byte}, {1'b1, eb});
    bus.command_ready = 1'b1;
    @(negedge clk);
    bus.command_ready = 1'b0;
    check($sformatf("%s_clear", name), {bus.command_valid, bus.command_error, bus.command_byte}, 0);
  endtask

  initial begin
    vec_t vt[8];
    bit   w;
    int   cnt, d;
    logic [7:0] b;
    logic par, stop;

    vt[0] = '{1'b0, 8'h1C, 1'b0, 1'b1, 11'h438, 8'h00, 1'b0, 1'b0};
    vt[1] = '{1'b0, 8'hFF, 1'b0, 1'b1, 11'h7FE, 8'h00, 1'b0, 1'b0};
    vt[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 11'h600, 8'h00, 1'b0, 1'b0};
    vt[3] = '{1'b1, 8'hED, 1'b1, 1'b1, 11'h000, 8'hED, 1'b0, 1'b1};
    vt[4] = '{1'b1, 8'hED, 1'b0, 1'b1, 11'h000, 8'hED, 1'b1, 1'b1};
    vt[5] = '{1'b1, 8'hED, 1'b1, 1'b0, 11'h000, 8'hED, 1'b1, 1'b0};
    vt[6] = '{1'b1, 8'h00, 1'b1, 1'b1, 11'h000, 8'h00, 1'b0, 1'b1};
    vt[7] = '{1'b1, 8'h80, 1'b0, 1'b1, 11'h000, 8'h80, 1'b0, 1'b1};

    bus.scan_code_valid = 1'b0;
    bus.scan_code_byte  = '0;
    bus.command_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_ready", bus.scan_code_ready, 0);
    check("rst_cmd", {bus.command_valid, bus.command_error, bus.command_byte}, 0);
    check("rst_abort", bus.tx_abort, 0);
    check("rst_out_low", {ps2_clk_out, ps2_data_out}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.scan_code_ready, 1);
    repeat (IDLE_HOLD + 5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (!vt[i].is_rx) begin
        offer(vt[i].data);
        tx_capture($sformatf("vec%0d_tx", i), vt[i].exp_frame);
      end else begin
        rx_run($sformatf("vec%0d_rx", i), vt[i].data, vt[i].par, vt[i].stop,
               vt[i].exp_byte, vt[i].exp_err, vt[i].exp_ack);
      end
    end

    // host inhibits during the d3 high half, then the byte must be resent whole
    repeat (IDLE_HOLD + 5) @(negedge clk);
    offer(8'h55);
    for (int k = 0; k < 4; k++) begin wait_oe(1'b0, w); wait_oe(1'b1, w); end
    wait_oe(1'b0, w);
    repeat (3) @(negedge clk);
    host_clk_low = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (bus.tx_abort) cnt++; end
    check("abort_pulses", cnt, 1);
    check("abort_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("abort_pending", bus.scan_code_ready, 0);
    repeat (10) @(negedge clk);
    host_clk_low = 1'b0;
    d = 0;
    while (!ps2_data_oe && d < 100) begin @(negedge clk); d++; end
    check("resend_delay_ok", (d >= IDLE_HOLD && d <= IDLE_HOLD + 6), 1);
    tx_capture("resend", 11'h6AA);

    // byte offer and request-to-send land in the same idle cycle
    repeat (IDLE_HOLD + 5) @(negedge clk);
    host_clk_low = 1'b1;
    @(negedge clk);
    check("sim_ready", bus.scan_code_ready, 1);
    bus.scan_code_valid = 1'b1;
    bus.scan_code_byte  = 8'hA7;
    @(negedge clk);
    bus.scan_code_valid = 1'b0;
    rx_run("sim_rx", 8'h3C, model_par(8'h3C), 1'b1, 8'h3C, 1'b0, 1'b1);
    check("sim_pending", bus.scan_code_ready, 0);
    tx_capture("sim_tx", model_frame(8'hA7));

    for (int it = 0; it < 12; it++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        offer(b);
        tx_capture($sformatf("rnd%0d_tx", it), model_frame(b));
      end else begin
        par  = model_par(b) ^ ($urandom_range(0, 4) == 0);
        stop = ($urandom_range(0, 5) != 0);
        rx_run($sformatf("rnd%0d_rx", it), b, par, stop, b,
               !stop || ((ones(b) + int'(par)) % 2 == 0), stop);
      end
    end

    // reset during pulse 5 of a host command
    repeat (IDLE_HOLD + 5) @(negedge clk);
    b = 8'h5A;
    @(negedge clk); host_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    host_data_low = 1'b1;
    repeat (10) @(negedge clk);
    host_clk_low = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_oe(1'b0, w);
      wait_oe(1'b1, w);
      if (k < 4) host_data_low = !b[k];
    end
    check("rstrx_active", ps2_clk_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rstrx_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rstrx_ready_low", bus.scan_code_ready, 0);
    reset = 1'b0;
    host_data_low = 1'b0;
    @(negedge clk);
    check("rstrx_ready", bus.scan_code_ready, 1);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (bus.command_valid || ps2_clk_oe) cnt++; end
    check("rstrx_quiet", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
